// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the EXE-stage multiply/divide unit.
package mips_pkg;

  // Multiply/divide opcode as presented by the decoder
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  // Iterative unit sequencing
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } muldiv_state_t;

  // One radix-2 step per operand bit
  localparam int MULDIV_STEPS = 32;

endpackage

// File: rtl/exe_muldiv_if.sv
// Issue/result bundle between the EXE-stage control and the multiply/divide unit.
interface exe_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  // Pipeline control side: issues operations and MT writes, observes HI/LO
  modport master (
    output start, op, a, b, kill, wr_hi, wr_lo, wdata,
    input  hi, lo, busy, done, stall
  );

  // Multiply/divide unit side
  modport slave (
    input  start, op, a, b, kill, wr_hi, wr_lo, wdata,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative 33-cycle MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Operands are reduced to magnitudes at launch, 32 radix-2 steps run on a
// shared 64-bit accumulator, and the sign fix-up happens in a final cycle.
module exe_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         clrn,
  exe_muldiv_if.slave  m
);

  localparam int CNT_W = $clog2(MULDIV_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULDIV_STEPS - 1);

  // Two's-complement negate when n is set (single width)
  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  // Two's-complement negate when n is set (double width)
  function automatic logic [2*WIDTH-1:0] neg_if2(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  muldiv_state_t      state;
  logic [CNT_W-1:0]   count;
  logic               op_div;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  muldiv_op_t         op_in;
  logic               in_signed;
  logic               in_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               busy;

  // Launch decode: sign flags and 32-bit unsigned magnitudes of the operands
  always_comb begin
    op_in     = muldiv_op_t'(m.op);
    in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    a_neg     = in_signed & m.a[WIDTH-1];
    b_neg     = in_signed & m.b[WIDTH-1];
    mag_a     = neg_if(a_neg, m.a);
    mag_b     = neg_if(b_neg, m.b);
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  // Divide keeps the partial remainder in the high half and shifts quotient bits
  // into the low half; the remainder never exceeds the divisor, so the 33-bit
  // difference only needs its top bit to decide restore vs. accept.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction applied in FIX; remainder follows the dividend's sign
  always_comb begin
    prod_fix = neg_if2(neg_res, acc);
    quo_fix  = neg_if(neg_res, acc[WIDTH-1:0]);
    rem_fix  = neg_if(neg_rem, acc[2*WIDTH-1:WIDTH]);
  end

  // Sequencer, working registers and HI/LO
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= S_IDLE;
      count   <= '0;
      op_div  <= 1'b0;
      acc     <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (m.start) begin
            // start wins over a coincident MTHI/MTLO
            op_div  <= in_div;
            opnd    <= in_div ? mag_b : mag_a;
            acc     <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (m.b == '0);
            a_raw   <= m.a;
            count   <= '0;
            state   <= S_CALC;
          end else begin
            if (m.wr_hi) hi_r <= m.wdata;
            if (m.wr_lo) lo_r <= m.wdata;
          end
        end
        S_CALC: begin
          if (m.kill) begin
            state <= S_IDLE;
          end else begin
            acc   <= op_div ? div_next : mul_next;
            count <= count + 1'b1;
            if (count == LAST_STEP) state <= S_FIX;
          end
        end
        S_FIX: begin
          // a flush arriving on the completion edge still discards the result
          if (!m.kill) begin
            if (!op_div) begin
              hi_r <= prod_fix[2*WIDTH-1:WIDTH];
              lo_r <= prod_fix[WIDTH-1:0];
            end else if (div0) begin
              hi_r <= a_raw;
              lo_r <= '1;
            end else begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end
            done_r <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign m.busy  = busy;
  assign m.done  = done_r;
  assign m.hi    = hi_r;
  assign m.lo    = lo_r;
  assign m.stall = m.start | busy;

endmodule

// File: tb/tb_exe_muldiv.sv
// Bench for exe_muldiv: directed vector table, hand-written MT/kill/reset
// sequences, and randomized operations against an arithmetic reference model.
module tb_exe_muldiv;

  logic clk;
  logic clrn;
  int   errors;
  int   checks;

  exe_muldiv_if #(.WIDTH(32)) bus ();

  exe_muldiv #(.WIDTH(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .m    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        tbl [11];
  int          lat;
  int          bc;
  int          dn_cnt;
  logic [31:0] mhi;
  logic [31:0] mlo;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [1:0]  rop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO results from plain integer arithmetic
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint      sa;
    longint      sb;
    longint      sp;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin
        sp = sa * sb;
        up = sp;
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFFFFFF;
        end else if (op == 2'b10) begin
          sp = sa / sb;
          up = sp;
          lo = up[31:0];
          sp = sa % sb;
          up = sp;
          hi = up[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  // Present start for one cycle; returns in the first busy cycle
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1;
    chk("stall_in_start_cycle", bus.stall, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count cycles until done; lat is measured in cycles after the start cycle
  task automatic wait_done(input int lat0, output int l, output int busy_cycles);
    l = lat0;
    busy_cycles = 0;
    forever begin
      if (bus.busy) busy_cycles++;
      if (bus.done) break;
      if (l >= 80) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles expected 34", l);
        break;
      end
      @(negedge clk);
      l++;
    end
    if (bus.done) begin
      chk("stall_low_with_done", bus.stall, 1'b0);
      @(negedge clk);
      chk("done_single_pulse", bus.done, 1'b0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clrn   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.kill  = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdata = '0;

    tbl[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3]  = '{2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
    tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    tbl[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[8]  = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    tbl[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    tbl[10] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_stall", bus.stall, 1'b0);
    clrn = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      launch(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(1, lat, bc);
      chk($sformatf("vec%0d_latency", i), lat, 34);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 33);
      chk($sformatf("vec%0d_hi", i), bus.hi, tbl[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo, tbl[i].lo);
    end

    // MTHI/MTLO in IDLE
    @(negedge clk);
    bus.wr_hi = 1'b1;
    bus.wdata = 32'h00001234;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    chk("mthi_hi", bus.hi, 32'h00001234);
    chk("mthi_lo_kept", bus.lo, 32'hFFFFFFEB);
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h00005555;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h00005555);

    // start with a coincident MTHI: the write is dropped; MTLO mid-run ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.wr_hi = 1'b1;
    bus.wdata = 32'h0000DEAD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    chk("mthi_dropped_on_start", bus.hi, 32'h00001234);
    repeat (4) @(negedge clk);
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h0000AAAA;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    chk("mtlo_ignored_busy", bus.lo, 32'h00005555);
    wait_done(6, lat, bc);
    chk("mt_seq_latency", lat, 34);
    chk("mt_seq_hi", bus.hi, 32'h0);
    chk("mt_seq_lo", bus.lo, 32'h6);

    // start while busy is ignored
    launch(2'b11, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6, lat, bc);
    chk("busy_start_latency", lat, 34);
    chk("busy_start_hi", bus.hi, 32'd2);
    chk("busy_start_lo", bus.lo, 32'd14);

    // kill mid-calculation
    launch(2'b11, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill_busy_low", bus.busy, 1'b0);
    dn_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dn_cnt++;
    end
    chk("kill_no_done", dn_cnt, 0);
    chk("kill_hi_kept", bus.hi, 32'd2);
    chk("kill_lo_kept", bus.lo, 32'd14);

    // kill on the FIX edge wins
    launch(2'b11, 32'd1000, 32'd3);
    repeat (32) @(negedge clk);
    chk("fix_cycle_busy", bus.busy, 1'b1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("fix_kill_no_done", bus.done, 1'b0);
    chk("fix_kill_busy", bus.busy, 1'b0);
    chk("fix_kill_hi", bus.hi, 32'd2);
    chk("fix_kill_lo", bus.lo, 32'd14);

    // asynchronous reset mid-operation
    launch(2'b00, 32'd7, 32'hFFFFFFFD);
    repeat (14) @(negedge clk);
    #2;
    clrn = 1'b0;
    #1;
    chk("async_rst_hi", bus.hi, 32'h0);
    chk("async_rst_lo", bus.lo, 32'h0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_done", bus.done, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    launch(2'b01, 32'd6, 32'd7);
    wait_done(1, lat, bc);
    chk("post_rst_latency", lat, 34);
    chk("post_rst_hi", bus.hi, 32'h0);
    chk("post_rst_lo", bus.lo, 32'd42);

    // randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model(rop, ra, rb, mhi, mlo);
      launch(rop, ra, rb);
      wait_done(1, lat, bc);
      chk($sformatf("rnd%0d_op%0d_latency", i, rop), lat, 34);
      chk($sformatf("rnd%0d_op%0d_a%h_b%h_hi", i, rop, ra, rb), bus.hi, mhi);
      chk($sformatf("rnd%0d_op%0d_a%h_b%h_lo", i, rop, ra, rb), bus.lo, mlo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
